eg_seq: RTL

Single-operator envelope sequencer for the FM envelope generator. It owns the envelope state machine, the global envelope counter and the 10-bit attenuation register. It drives `state_V`, `rate_V` and `cnt_V` to the external step-decision block and consumes that block's `step_V` to decide whether the attenuation moves on each envelope tick. It sits between the operator register file (rates, sustain level, key scale, keycode, key-on) and the operator attenuation path.

---
 rtl/eg_seq.sv | 130 +++++++++++++
 1 files changed

// File: rtl/eg_seq.sv
// Single-operator envelope sequencer: envelope state machine, global envelope
// counter and 10-bit attenuation register for one FM operator.
module eg_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       eg_tick,
  input  logic       keyon,
  input  logic [4:0] ar,
  input  logic [4:0] d1r,
  input  logic [4:0] d2r,
  input  logic [3:0] rr,
  input  logic [3:0] sl,
  input  logic [1:0] ks,
  input  logic [4:0] keycode,
  input  logic       step_V,
  output logic [2:0] state_V,
  output logic [5:0] rate_V,
  output logic [2:0] cnt_V,
  output logic [9:0] eg
);

  typedef enum logic [2:0] {
    ATTACK  = 3'd0,
    DECAY1  = 3'd1,
    DECAY2  = 3'd2,
    RELEASE = 3'd7
  } state_t;

  state_t      state;
  logic [14:0] eg_cnt;
  logic        keyon_l;

  logic [4:0]  base;
  logic [4:0]  kcs;
  logic [5:0]  attack_rate;
  logic [3:0]  rate_hi;
  logic [3:0]  shift;
  logic [14:0] low_mask;
  logic        do_step;
  logic [4:0]  inc;
  logic [13:0] prod;
  logic [10:0] att_dec;
  logic [9:0]  eg_att;
  logic [10:0] dec_sum;
  logic [9:0]  eg_dec;
  logic [9:0]  slv;
  logic        key_rise;
  logic        key_fall;

  // Rate is twice the base plus the key-scale contribution, saturated at 63;
  // a zero base rate always yields zero so the envelope freezes.
  function automatic logic [5:0] calc_rate(input logic [4:0] b, input logic [4:0] k);
    logic [6:0] sum;
    sum = {1'b0, b, 1'b0} + {2'b00, k};
    if (b == 5'd0)
      return 6'd0;
    else if (sum > 7'd63)
      return 6'd63;
    else
      return sum[5:0];
  endfunction

  always_comb begin
    base = {rr, 1'b1};
    case (state)
      ATTACK:  base = ar;
      DECAY1:  base = d1r;
      DECAY2:  base = d2r;
      default: base = {rr, 1'b1};
    endcase
  end

  assign kcs         = keycode >> (2'd3 - ks);
  assign rate_V      = calc_rate(base, kcs);
  assign attack_rate = calc_rate(ar, kcs);

  assign rate_hi  = rate_V[5:2];
  assign shift    = (rate_hi < 4'd11) ? (4'd11 - rate_hi) : 4'd0;
  assign cnt_V    = 3'(eg_cnt >> shift);
  assign low_mask = (15'd1 << shift) - 15'd1;
  assign do_step  = ((eg_cnt & low_mask) == 15'd0) && step_V && (rate_V != 6'd0);
  assign inc      = (rate_hi < 4'd12) ? 5'd1 : (5'd1 << (rate_hi - 4'd11));

  // Attack moves exponentially towards zero; decay and release move linearly
  // towards silence. Both saturate at their end of the range.
  assign prod    = {4'b0000, eg} * {9'b0, inc};
  assign att_dec = 11'(prod >> 4) + 11'd1;
  assign eg_att  = (att_dec >= {1'b0, eg}) ? 10'd0 : (eg - att_dec[9:0]);
  assign dec_sum = {1'b0, eg} + {6'b0, inc};
  assign eg_dec  = (dec_sum > 11'h3FF) ? 10'h3FF : dec_sum[9:0];

  assign slv      = (sl == 4'd15) ? 10'h3E0 : {1'b0, sl, 5'b0};
  assign key_rise = keyon && !keyon_l;
  assign key_fall = !keyon && keyon_l;

  // Key edges win over level transitions and suppress the attenuation step;
  // otherwise level transitions look at the pre-update eg and the step uses
  // the state held before this tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RELEASE;
      eg      <= 10'h3FF;
      eg_cnt  <= 15'd0;
      keyon_l <= 1'b0;
    end else if (eg_tick) begin
      keyon_l <= keyon;
      eg_cnt  <= eg_cnt + 15'd1;
      if (key_rise) begin
        if (attack_rate >= 6'd62) begin
          eg    <= 10'd0;
          state <= DECAY1;
        end else begin
          state <= ATTACK;
        end
      end else if (key_fall) begin
        state <= RELEASE;
      end else begin
        if (state == ATTACK && eg == 10'd0)
          state <= DECAY1;
        else if (state == DECAY1 && eg >= slv)
          state <= DECAY2;
        if (do_step)
          eg <= (state == ATTACK) ? eg_att : eg_dec;
      end
    end
  end

  assign state_V = state;

endmodule
